vga_sync_decoder: RTL



---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_edge_det.sv | 31 +++
 rtl/vga_sync_decoder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing types and defaults.
// Used by the timing generator and the sync decoder.
package vga_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } vga_state_e;

  localparam int HDISP_DEF = 800;
  localparam int VDISP_DEF = 480;
  localparam int XW        = 11;
  localparam int YW        = 10;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Two-stage input register with registered rise/fall pulses.
// lvl, rise and fall are aligned to the same sample.
module vga_edge_det (
  input  logic CLK,
  input  logic NRST,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic q1;
  logic q2;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      q1   <= 1'b0;
      q2   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      q1   <= d;
      q2   <= q1;
      rise <= q1 & ~q2;
      fall <= ~q1 & q2;
    end
  end

  assign lvl = q2;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers x/y, frame start and lock from HS/VS/BLANK.
// Optional VGA_DEC_STATS_EN adds saturating good-frame and error counters.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int HDISP       = HDISP_DEF,
  parameter int VDISP       = VDISP_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          CLK,
  input  logic          NRST,
  input  logic          VGA_HS,
  input  logic          VGA_VS,
  input  logic          VGA_BLANK,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          pix_valid,
  output logic          frame_start,
  output logic          locked,
  output logic          err,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   err_cnt
);

  localparam logic [XW-1:0] HMAX  = XW'(HDISP);
  localparam logic [XW-1:0] HLAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] VMAX  = YW'(VDISP);
  localparam logic [7:0]    LF8   = 8'(LOCK_FRAMES);

  logic          hs_q;
  logic          vs_lvl, vs_rise, vs_fall;
  logic          bl_lvl, bl_rise, bl_fall;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  vga_state_e    state, state_n;
  logic [7:0]    good, good_n;
  logic          viol, err_n, frame_ok;
  logic          unused;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) hs_q <= 1'b1;
    else       hs_q <= VGA_HS;
  end

  vga_edge_det u_vs (
    .CLK  (CLK),
    .NRST (NRST),
    .d    (VGA_VS),
    .lvl  (vs_lvl),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  vga_edge_det u_bl (
    .CLK  (CLK),
    .NRST (NRST),
    .d    (VGA_BLANK),
    .lvl  (bl_lvl),
    .rise (bl_rise),
    .fall (bl_fall)
  );

  // HS is observed only; lines are framed by BLANK
  assign unused = ^{hs_q, vs_lvl, vs_rise};

  assign viol = (state != SEARCH) & (
      (bl_fall & (col != HLAST))
    | (bl_lvl & ~bl_rise & (col == HLAST))
    | (bl_rise & (row == VMAX))
    | (vs_fall & (row != VMAX)));

  always_comb begin
    state_n  = state;
    good_n   = good;
    err_n    = 1'b0;
    frame_ok = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_n = MEASURE;
          good_n  = '0;
        end
      end
      default: begin
        if (viol) begin
          state_n = SEARCH;
          good_n  = '0;
          err_n   = 1'b1;
        end else if (vs_fall) begin
          frame_ok = 1'b1;
          if (good < LF8) good_n = good + 8'd1;
          if (good_n >= LF8) state_n = LOCKED;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state       <= SEARCH;
      good        <= '0;
      err         <= 1'b0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      col         <= '0;
      row         <= '0;
    end else begin
      state       <= state_n;
      good        <= good_n;
      err         <= err_n;
      frame_start <= vs_fall;
      pix_valid   <= bl_lvl;
      if (bl_rise)
        col <= '0;
      else if (bl_lvl && col != HMAX)
        col <= col + 1'b1;
      if (vs_fall)
        row <= '0;
      else if (bl_fall && row != VMAX)
        row <= row + 1'b1;
    end
  end

  assign x      = col;
  assign y      = row;
  assign locked = (state == LOCKED);

`ifdef VGA_DEC_STATS_EN
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_ok) frame_cnt <= sat_inc16(frame_cnt);
      if (err_n)    err_cnt   <= sat_inc16(err_cnt);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = frame_ok;
  assign frame_cnt    = '0;
  assign err_cnt      = '0;
`endif

endmodule
